// File: rtl/neuron_ctrl_pkg.sv
// rtl/neuron_ctrl_pkg.sv - shared state encoding and default widths for the training sequencer
package neuron_ctrl_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int EPOCH_W_DEF = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    FETCH,
    LOAD,
    CALC,
    WAIT,
    UPDATE,
    NEXT,
    CHECK,
    FINISH
  } state_t;

endpackage

// File: rtl/neuron_train_seq_if.sv
// rtl/neuron_train_seq_if.sv - sequencer-to-datapath strobes and sample memory address
interface neuron_train_seq_if #(
  parameter int ADDR_W = 4
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              ld_x;
  logic              clr_w;
  logic              calc_go;
  logic              calc_done;
  logic              y_eq_t;
  logic              ld_w;

  modport master (
    output mem_addr, mem_rd, ld_x, clr_w, calc_go, ld_w,
    input  calc_done, y_eq_t
  );

  modport slave (
    input  mem_addr, mem_rd, ld_x, clr_w, calc_go, ld_w,
    output calc_done, y_eq_t
  );

endinterface

// File: rtl/neuron_train_seq_sat_counter.sv
// rtl/neuron_train_seq_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/neuron_train_seq.sv
// rtl/neuron_train_seq.sv - epoch/sample sequencer driving the perceptron training datapath
module neuron_train_seq
  import neuron_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int EPOCH_W = EPOCH_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   last_addr,
  input  logic [EPOCH_W-1:0]  max_epochs,
  neuron_train_seq_if.master  dp,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic [EPOCH_W-1:0]  epoch_cnt,
  output logic [ADDR_W:0]     err_cnt
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  last_q;
  logic [EPOCH_W-1:0] max_q;
  logic [EPOCH_W-1:0] epoch_next;
  logic               aborting;
  logic               at_last;
  logic               clean_epoch;
  logic               limit_hit;
  logic               ep_clr, ep_inc, err_clr, err_inc;

  assign aborting    = abort && (state_q != IDLE);
  assign at_last     = (addr_q == last_q);
  assign clean_epoch = (err_cnt == '0);
  // Limit is judged against the count this CHECK is about to write.
  assign epoch_next  = (epoch_cnt == {EPOCH_W{1'b1}}) ? epoch_cnt : epoch_cnt + 1'b1;
  assign limit_hit   = (max_q != '0) && (epoch_next == max_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = CALC;
      CALC:    state_d = WAIT;
      WAIT:    if (dp.calc_done) state_d = dp.y_eq_t ? NEXT : UPDATE;
      UPDATE:  state_d = NEXT;
      NEXT:    state_d = at_last ? CHECK : FETCH;
      CHECK:   state_d = (clean_epoch || limit_hit) ? FINISH : FETCH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (aborting) state_d = IDLE;
  end

  assign dp.mem_addr = addr_q;
  assign dp.mem_rd   = (state_q == FETCH);
  assign dp.ld_x     = (state_q == LOAD);
  assign dp.clr_w    = (state_q == INIT);
  assign dp.calc_go  = (state_q == CALC);
  assign dp.ld_w     = (state_q == UPDATE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      last_q    <= '0;
      max_q     <= '0;
      converged <= 1'b0;
    end else if (aborting) begin
      converged <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          addr_q    <= '0;
          last_q    <= last_addr;
          max_q     <= max_epochs;
          converged <= 1'b0;
        end
        NEXT: if (!at_last) addr_q <= addr_q + 1'b1;
        CHECK: begin
          if (clean_epoch) begin
            converged <= 1'b1;
          end else if (limit_hit) begin
            converged <= 1'b0;
          end else begin
            addr_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ep_clr  = !aborting && (state_q == INIT);
  assign ep_inc  = !aborting && (state_q == CHECK);
  assign err_inc = !aborting && (state_q == WAIT) && dp.calc_done && !dp.y_eq_t;
  assign err_clr = !aborting && ((state_q == INIT) ||
                                 ((state_q == CHECK) && !clean_epoch && !limit_hit));

  sat_counter #(.W(EPOCH_W)) u_epoch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ep_clr),
    .inc (ep_inc),
    .q   (epoch_cnt)
  );

  sat_counter #(.W(ADDR_W + 1)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (err_inc),
    .q   (err_cnt)
  );

endmodule

// File: tb/tb_neuron_train_seq.sv
// tb/tb_neuron_train_seq.sv - directed bench for neuron_train_seq with a latency-programmable datapath model
module tb_neuron_train_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] last_addr;
  logic [7:0] max_epochs;
  logic       busy;
  logic       done;
  logic       converged;
  logic [7:0] epoch_cnt;
  logic [4:0] err_cnt;

  neuron_train_seq_if #(.ADDR_W(4)) dp ();

  neuron_train_seq #(.ADDR_W(4), .EPOCH_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .last_addr  (last_addr),
    .max_epochs (max_epochs),
    .dp         (dp),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .epoch_cnt  (epoch_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Datapath model: calc_done rises lat cycles after calc_go; mask bits mark wrong samples.
  int          lat = 1;
  int          lat_cnt = 0;
  logic [15:0] mask_first = '0;
  logic [15:0] mask_rest  = '0;

  always @(posedge clk) begin
    if (rst) lat_cnt <= 0;
    else if (dp.calc_go) lat_cnt <= lat;
    else if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
  end

  assign dp.calc_done = (lat_cnt == 1);
  assign dp.y_eq_t    = (epoch_cnt == 8'd0) ? ~mask_first[dp.mem_addr] : ~mask_rest[dp.mem_addr];

  int tick = 0;
  int t0 = 0;
  int clr_cyc, done_cyc, go_cyc, cd_cyc, ldw_n, done_n, err_peak;
  int addr_q[$];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) tick++;

  always @(negedge clk) begin
    if (dp.clr_w && clr_cyc < 0) clr_cyc = tick - t0;
    if (done) begin
      done_n++;
      if (done_cyc < 0) done_cyc = tick - t0;
    end
    if (dp.calc_go && go_cyc < 0) go_cyc = tick - t0;
    if (dp.calc_done && cd_cyc < 0) cd_cyc = tick - t0;
    if (dp.ld_w) ldw_n++;
    if (dp.mem_rd) addr_q.push_back(int'(dp.mem_addr));
    if (int'(err_cnt) > err_peak) err_peak = int'(err_cnt);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    clr_cyc  = -1;
    done_cyc = -1;
    go_cyc   = -1;
    cd_cyc   = -1;
    ldw_n    = 0;
    done_n   = 0;
    err_peak = 0;
    addr_q.delete();
  endtask

  task automatic start_run(input logic [3:0] la, input logic [7:0] me);
    last_addr  = la;
    max_epochs = me;
    clear_rec();
    start = 1'b1;
    t0 = tick;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k = 0;
    while (done_n == 0 && k < max_cyc) begin
      step(1);
      k++;
    end
    chk("done_seen", done_n > 0, 1);
  endtask

  task automatic wait_wait_of_sample2(input int max_cyc);
    int k = 0;
    while (!(epoch_cnt == 8'd1 && dp.calc_go && dp.mem_addr == 4'd2) && k < max_cyc) begin
      step(1);
      k++;
    end
    chk("reach_sample2", k < max_cyc, 1);
    step(1);
  endtask

  task automatic chk_idle_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_strobes"}, {dp.mem_rd, dp.ld_x, dp.clr_w, dp.calc_go, dp.ld_w}, 0);
    chk({tag, "_epoch"}, epoch_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_conv"}, converged, 0);
    chk({tag, "_addr"}, dp.mem_addr, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    last_addr = 4'd3;
    max_epochs = 8'd0;
    clear_rec();

    // Reset held two cycles with start high
    step(1);
    chk_idle_reset_vals("rst1");
    step(1);
    chk_idle_reset_vals("rst2");
    rst = 1'b0;
    start = 1'b0;
    step(1);
    chk("post_rst_busy", busy, 0);

    // Clean single epoch, L=1
    lat = 1;
    mask_first = '0;
    mask_rest = '0;
    start_run(4'd3, 8'd0);
    wait_done(100);
    chk("clean_clr_cyc", clr_cyc, 1);
    chk("clean_go_cyc", go_cyc, 4);
    chk("clean_cd_cyc", cd_cyc, 5);
    chk("clean_done_cyc", done_cyc, 23);
    chk("clean_nreads", addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_q.size()) chk("clean_addr", addr_q[i], i);
    end
    chk("clean_ldw", ldw_n, 0);
    chk("clean_conv", converged, 1);
    chk("clean_epoch", epoch_cnt, 1);
    chk("clean_err", err_cnt, 0);
    chk("clean_busy", busy, 0);

    // Two epochs: samples 1 and 2 wrong in the first
    mask_first = 16'b0110;
    mask_rest = '0;
    start_run(4'd3, 8'd0);
    wait_done(200);
    chk("two_ldw", ldw_n, 2);
    chk("two_err_peak", err_peak, 2);
    chk("two_err", err_cnt, 0);
    chk("two_epoch", epoch_cnt, 2);
    chk("two_conv", converged, 1);
    chk("two_nreads", addr_q.size(), 8);
    chk("two_done_cyc", done_cyc, 46);

    // Epoch limit 3, sample 0 always wrong
    mask_first = 16'b0001;
    mask_rest = 16'b0001;
    start_run(4'd1, 8'd3);
    wait_done(200);
    chk("lim_done_cyc", done_cyc, 38);
    chk("lim_epoch", epoch_cnt, 3);
    chk("lim_conv", converged, 0);
    chk("lim_err", err_cnt, 1);
    chk("lim_ldw", ldw_n, 3);

    // Single sample, L=4, stray start during WAIT
    lat = 4;
    mask_first = '0;
    mask_rest = '0;
    start_run(4'd0, 8'd0);
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(100);
    chk("lat_go_cyc", go_cyc, 4);
    chk("lat_cd_cyc", cd_cyc, 8);
    chk("lat_done_cyc", done_cyc, 11);
    step(3);
    chk("lat_done_once", done_n, 1);
    chk("lat_busy_after", busy, 0);
    chk("lat_conv", converged, 1);

    // Abort in WAIT of sample 2, second epoch
    lat = 2;
    mask_first = 16'b0001;
    mask_rest = 16'b0001;
    start_run(4'd3, 8'd0);
    wait_wait_of_sample2(300);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_conv", converged, 0);
    chk("abort_epoch", epoch_cnt, 1);
    chk("abort_err", err_cnt, 1);
    chk("abort_addr", dp.mem_addr, 2);
    step(5);
    chk("abort_no_done", done_n, 0);
    chk("abort_stay_idle", busy, 0);
    chk("abort_epoch_hold", epoch_cnt, 1);

    // Same run, reset instead of abort
    start_run(4'd3, 8'd0);
    wait_wait_of_sample2(300);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_idle_reset_vals("midrst");
    step(3);
    chk("midrst_no_done", done_n, 0);
    chk("midrst_stay_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
